// File: rtl/dec_4_16_hold_pkg.sv
// Shared types and widths for the 4-to-16 hold decoder.
package dec_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

endpackage

// File: rtl/dec_4_16_hold_dec_3_8.sv
// 3-to-8 one-hot decoder with bank enable; all zeros when disabled.
module dec_3_8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] d
);

  // Drive the addressed line only when this bank is selected.
  always_comb begin
    d = '0;
    if (en) begin
      d[a] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_4_16_hold.sv
// Registered 4-to-16 one-hot decoder with valid/ready intake, programmable hold
// time and a one-cycle done gap after each hold.
module dec_4_16_hold
  import dec_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              busy,
  output logic              done
);

  if (HOLD < 1 || HOLD > 16) begin : gen_hold_check
    $fatal(1, "dec_4_16_hold: HOLD=%0d outside 1..16", HOLD);
  end

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_d;
  logic               accept;
  logic [7:0]         dec_lo;
  logic [7:0]         dec_hi;

  assign code_ready = (state == StIdle) && en;
  assign accept     = code_valid && code_ready;

  // Decode the code about to be captured so y can load on the accept edge itself.
  assign code_d = accept ? code : code_q;

  dec_3_8 u_dec_lo (
    .en (~code_d[3]),
    .a  (code_d[2:0]),
    .d  (dec_lo)
  );

  dec_3_8 u_dec_hi (
    .en (code_d[3]),
    .a  (code_d[2:0]),
    .d  (dec_hi)
  );

  // FSM, hold counter and registered outputs; reset abandons any hold without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      code_q  <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (accept) begin
            code_q  <= code;
            y       <= {dec_hi, dec_lo};
            y_valid <= 1'b1;
            cnt     <= HoldLoad;
            busy    <= 1'b1;
            state   <= StDrive;
          end
        end
        StDrive: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b1;
            state   <= StGap;
          end
        end
        StGap: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          y       <= '0;
          y_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_4_16_hold.sv
// Directed bench for dec_4_16_hold: three instances (HOLD = 4, 1, 16) share
// stimulus; each scenario checks only the instance it targets.
module tb_dec_4_16_hold;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  code;
  logic        code_valid;

  logic        rdy_w   [3];
  logic [15:0] y_w     [3];
  logic        yv_w    [3];
  logic        busy_w  [3];
  logic        done_w  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_4_16_hold #(.HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid),
    .code_ready(rdy_w[0]), .y(y_w[0]), .y_valid(yv_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  dec_4_16_hold #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid),
    .code_ready(rdy_w[1]), .y(y_w[1]), .y_valid(yv_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  dec_4_16_hold #(.HOLD(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid),
    .code_ready(rdy_w[2]), .y(y_w[2]), .y_valid(yv_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  typedef struct {
    logic [3:0]  code;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!rdy_w[d] && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'd0, rdy_w[d]}, 32'd1);
  endtask

  // Checks a full hold starting in the first cycle after the accept edge.
  task automatic finish_op(input int d, input logic [15:0] exp_y, input int h, input string tag);
    for (int i = 0; i < h; i++) begin
      chk({tag, "_y"}, {16'd0, y_w[d]}, {16'd0, exp_y});
      chk({tag, "_yv"}, {31'd0, yv_w[d]}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy_w[d]}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done_w[d]}, 32'd0);
      step();
    end
    chk({tag, "_gap_y"}, {16'd0, y_w[d]}, 32'd0);
    chk({tag, "_gap_yv"}, {31'd0, yv_w[d]}, 32'd0);
    chk({tag, "_gap_done"}, {31'd0, done_w[d]}, 32'd1);
    chk({tag, "_gap_busy"}, {31'd0, busy_w[d]}, 32'd1);
    chk({tag, "_gap_rdy"}, {31'd0, rdy_w[d]}, 32'd0);
    step();
    chk({tag, "_end_done"}, {31'd0, done_w[d]}, 32'd0);
    chk({tag, "_end_busy"}, {31'd0, busy_w[d]}, 32'd0);
    chk({tag, "_end_rdy"}, {31'd0, rdy_w[d]}, {31'd0, en});
  endtask

  task automatic run_op(input logic [3:0] c, input logic [15:0] exp_y, input string tag);
    wait_ready(0);
    code       = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    finish_op(0, exp_y, 4, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  16'h0001};
    vecs[1]  = '{4'd1,  16'h0002};
    vecs[2]  = '{4'd2,  16'h0004};
    vecs[3]  = '{4'd3,  16'h0008};
    vecs[4]  = '{4'd4,  16'h0010};
    vecs[5]  = '{4'd5,  16'h0020};
    vecs[6]  = '{4'd6,  16'h0040};
    vecs[7]  = '{4'd7,  16'h0080};
    vecs[8]  = '{4'd8,  16'h0100};
    vecs[9]  = '{4'd9,  16'h0200};
    vecs[10] = '{4'd10, 16'h0400};
    vecs[11] = '{4'd11, 16'h0800};
    vecs[12] = '{4'd12, 16'h1000};
    vecs[13] = '{4'd13, 16'h2000};
    vecs[14] = '{4'd14, 16'h4000};
    vecs[15] = '{4'd15, 16'h8000};

    rst = 1'b1; en = 1'b0; code = '0; code_valid = 1'b0;
    do_reset();

    // Reset state; code_ready follows en.
    chk("rst_y", {16'd0, y_w[0]}, 32'd0);
    chk("rst_yv", {31'd0, yv_w[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("rst_done", {31'd0, done_w[0]}, 32'd0);
    chk("rst_rdy_en0", {31'd0, rdy_w[0]}, 32'd0);
    en = 1'b1;
    #1;
    chk("rst_rdy_en1", {31'd0, rdy_w[0]}, 32'd1);

    // Sweep all codes.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].code, vecs[i].exp_y, $sformatf("sweep%0d", i));
    end

    // Back-to-back pressure: valid never drops, code 3 then 12.
    wait_ready(0);
    code = 4'd3;
    code_valid = 1'b1;
    step();
    code = 4'd12;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_y3", {16'd0, y_w[0]}, 32'h0008);
      step();
    end
    chk("b2b_gap_y", {16'd0, y_w[0]}, 32'd0);
    chk("b2b_gap_done", {31'd0, done_w[0]}, 32'd1);
    step();
    chk("b2b_idle_y", {16'd0, y_w[0]}, 32'd0);
    chk("b2b_idle_rdy", {31'd0, rdy_w[0]}, 32'd1);
    step();
    code_valid = 1'b0;
    finish_op(0, 16'h1000, 4, "b2b_y12");

    // en gating.
    en = 1'b0;
    code = 4'd5;
    code_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en0_rdy", {31'd0, rdy_w[0]}, 32'd0);
      chk("en0_y", {16'd0, y_w[0]}, 32'd0);
    end
    en = 1'b1;
    #1;
    chk("en1_rdy", {31'd0, rdy_w[0]}, 32'd1);
    step();
    code_valid = 1'b0;
    finish_op(0, 16'h0020, 4, "en1_op");

    // Reset in the 2nd DRIVE cycle of code 7.
    wait_ready(0);
    code = 4'd7;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    chk("mid_y_a0", {16'd0, y_w[0]}, 32'h0080);
    step();
    chk("mid_y_a1", {16'd0, y_w[0]}, 32'h0080);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_y", {16'd0, y_w[0]}, 32'd0);
    chk("mid_rst_yv", {31'd0, yv_w[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rdy_w[0]}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_nodone", {31'd0, done_w[0]}, 32'd0);
      step();
    end

    // Ignore-while-busy: code 10 pulse during DRIVE of code 2.
    wait_ready(0);
    code = 4'd2;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    chk("ign_y_a0", {16'd0, y_w[0]}, 32'h0004);
    code = 4'd10;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ign_y_hold", {16'd0, y_w[0]}, 32'h0004);
      step();
    end
    chk("ign_gap_done", {31'd0, done_w[0]}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ign_no10_y", {16'd0, y_w[0]}, 32'd0);
      chk("ign_no10_busy", {31'd0, busy_w[0]}, 32'd0);
    end

    // Boundary HOLD = 1 and HOLD = 16, accepted on the same edge after reset.
    do_reset();
    code = 4'd6;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("h1_yv_c%0d", i), {31'd0, yv_w[1]}, (i < 1) ? 32'd1 : 32'd0);
      chk($sformatf("h1_done_c%0d", i), {31'd0, done_w[1]}, (i == 1) ? 32'd1 : 32'd0);
      chk($sformatf("h1_rdy_c%0d", i), {31'd0, rdy_w[1]}, (i >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("h16_yv_c%0d", i), {31'd0, yv_w[2]}, (i < 16) ? 32'd1 : 32'd0);
      chk($sformatf("h16_y_c%0d", i), {16'd0, y_w[2]}, (i < 16) ? 32'h0040 : 32'd0);
      chk($sformatf("h16_done_c%0d", i), {31'd0, done_w[2]}, (i == 16) ? 32'd1 : 32'd0);
      chk($sformatf("h16_rdy_c%0d", i), {31'd0, rdy_w[2]}, (i >= 17) ? 32'd1 : 32'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // One-hot invariant on every instance, sampled away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (!$onehot0(y_w[d])) begin
          n_fail++;
          $display("FAIL onehot dut%0d: got %h required at most one bit set", d, y_w[d]);
        end
      end
    end
  end

endmodule
